v_vram_resp: RTL and testbench
==============================

Name: v_vram_resp

Overview:
- Responder end of the vector-core VRAM port. Services the `vram_r_*` and `vram_w_*` requests issued by the vector CPU.
- Holds a VLEN-wide, word-indexed storage array with bit-granular masked writes and a registered read path.
- Runs a post-reset clear sequencer that zeroes the array before it accepts any traffic.
- Sits beside `v_rvcpu` in the SoC/testbench top, in place of a behavioural VRAM model.

Parameters:
- VRAM_DW, `VLEN (256): data, mask and entry width in bits.
- VRAM_AW, 64: request address width. Addresses are byte addresses.
- DEPTH, 1024: number of VRAM_DW entries; must be a power of 2.
- BASE_ADDR, 64'h0: byte address of entry 0.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- vram_r_ena  in  1  read request, sampled each cycle
- vram_r_addr  in  VRAM_AW  read byte address
- vram_r_data  out  VRAM_DW  registered read data
- vram_r_valid  out  1  vram_r_data holds the result of the read accepted in the previous cycle
- vram_w_ena  in  1  write request, sampled each cycle
- vram_w_addr  in  VRAM_AW  write byte address
- vram_w_data  in  VRAM_DW  write data
- vram_w_mask  in  VRAM_DW  per-bit write enable (1 = update the bit)
- vram_busy  out  1  clear sequencer active; requests are ignored
- vram_err  out  1  one-cycle pulse on an out-of-range accepted request

Behaviour:
- Reset (async assert): state=CLEAR, clr_idx=0, vram_busy=1, vram_r_data=0, vram_r_valid=0, vram_err=0. Array contents are not reset asynchronously.
- Index calculation:
  - idx = (addr - BASE_ADDR) >> log2(VRAM_DW/8). Low address bits are ignored, so misaligned addresses select the containing entry.
  - In range: BASE_ADDR <= addr and idx < DEPTH, with the subtraction done at full VRAM_AW width and no wrap.
- State CLEAR:
  - Each cycle writes mem[clr_idx] = 0, then clr_idx += 1.
  - When clr_idx == DEPTH-1 has been written, go to READY next cycle and drop vram_busy. The clear takes exactly DEPTH cycles after reset release.
  - Requests arriving during CLEAR are dropped silently: no write, vram_r_valid=0, vram_err=0.
- State READY, write:
  - When vram_w_ena is high and in range: mem[idx] <= (mem[idx] & ~vram_w_mask) | (vram_w_data & vram_w_mask).
  - mask=0 leaves the entry unchanged and still counts as accepted.
- State READY, read:
  - When vram_r_ena is high, the next cycle gives vram_r_valid=1 and vram_r_data=mem[idx]. Latency is 1 cycle; one read per cycle, fully pipelined.
  - When vram_r_ena is low, the next cycle gives vram_r_valid=0 and vram_r_data holds its previous value.
- Same-cycle read and write to the same idx: write-first. The read returns the merged (post-write) value.
- Same-cycle read and write to different idx: both are serviced independently.
- Out of range:
  - A write is dropped.
  - A read returns vram_r_data=0 with vram_r_valid=1.
  - vram_err=1 in the cycle after acceptance. If both requests are out of range in the same cycle, a single pulse is produced.
- Reset asserted mid-clear or mid-traffic: the FSM restarts CLEAR from index 0 and any in-flight read is discarded (valid=0).
- No other states exist; READY is terminal until the next reset.

Decomposition:
- Shared package/defines (`v_defines.v`):
  - `VLEN, `VRAM_DATA_BUS, `VRAM_ADDR_BUS
  - new `VRAM_DEPTH and `VRAM_BASE constants
  - state encodings VRAM_ST_CLEAR=1'b0, VRAM_ST_READY=1'b1
- One sub-module: `v_vram_addr_map`, combinational. Converts an address to {in_range, idx}. Instantiated twice, once for the read address and once for the write address.
- The masked merge and the array stay in the top module.

Test Plan:
- Reset release -> vram_busy stays 1 for exactly 1024 cycles, then 0. A read to addr 0x7FE0 immediately after returns 0 with valid=1.
- Write addr 0x40, data all-0xA5, mask all-1. Next cycle read 0x40 -> cycle+1 gives r_data all-0xA5, r_valid=1, err=0.
- Write 0x40, data all-0xFF, mask = 0x0000...00FF. Read 0x40 -> low byte 0xFF, remaining bytes 0xA5. Read 0x5F (misaligned) -> same value.
- Same cycle: write 0x80 with data 0x1234 under a full mask, and read 0x80 -> next cycle r_data=0x1234 (write-first).
- Write to addr 0x8000 (idx 1024) -> vram_err pulses one cycle, no entry changes. Read 0x8000 -> r_data=0, valid=1, err=1.
- Assert rst at clear cycle 500 and during a read -> r_valid=0, busy=1. After release the clear takes a full 1024 cycles, and the entry at 0x40 reads 0.

Source files
------------

// File: rtl/v_vram_resp_pkg.sv
// Shared constants and state encoding for the vector-core VRAM responder.
// Widths here are the defaults picked up by v_vram_resp and v_vram_addr_map.
package v_vram_resp_pkg;

  localparam int VLEN          = 256;
  localparam int VRAM_DATA_BUS = VLEN;
  localparam int VRAM_ADDR_BUS = 64;
  localparam int VRAM_DEPTH    = 1024;
  localparam logic [VRAM_ADDR_BUS-1:0] VRAM_BASE = 64'h0;

  typedef enum logic {
    VRAM_ST_CLEAR = 1'b0,
    VRAM_ST_READY = 1'b1
  } vram_state_e;

endpackage

// File: rtl/v_vram_addr_map.sv
// Byte address to VRAM entry index, with a range check against the window
// [BASE, BASE + DEPTH*DW/8). Purely combinational.
module v_vram_addr_map
  import v_vram_resp_pkg::*;
#(
  parameter int AW    = VRAM_ADDR_BUS,
  parameter int DW    = VRAM_DATA_BUS,
  parameter int DEPTH = VRAM_DEPTH,
  parameter int IW    = $clog2(DEPTH),
  parameter logic [AW-1:0] BASE = '0
) (
  input  logic [AW-1:0] addr,
  output logic          in_range,
  output logic [IW-1:0] idx
);

  localparam int SHIFT = $clog2(DW / 8);
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  logic [AW-1:0] offs;
  logic [AW-1:0] word;

  // The full-width word index is compared, so addresses far past the window
  // never alias back onto a low entry.
  always_comb begin
    offs     = addr - BASE;
    word     = offs >> SHIFT;
    in_range = (addr >= BASE) && (word < DEPTH_W);
    idx      = word[IW-1:0];
  end

endmodule

// File: rtl/v_vram_resp.sv
// VRAM responder: word-indexed array with bit-masked writes, a 1-cycle
// registered read path (write-first on collisions) and a post-reset clear.
module v_vram_resp
  import v_vram_resp_pkg::*;
#(
  parameter int VRAM_DW = VRAM_DATA_BUS,
  parameter int VRAM_AW = VRAM_ADDR_BUS,
  parameter int DEPTH   = VRAM_DEPTH,
  parameter logic [VRAM_AW-1:0] BASE_ADDR = VRAM_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vram_r_ena,
  input  logic [VRAM_AW-1:0] vram_r_addr,
  output logic [VRAM_DW-1:0] vram_r_data,
  output logic               vram_r_valid,
  input  logic               vram_w_ena,
  input  logic [VRAM_AW-1:0] vram_w_addr,
  input  logic [VRAM_DW-1:0] vram_w_data,
  input  logic [VRAM_DW-1:0] vram_w_mask,
  output logic               vram_busy,
  output logic               vram_err
);

  localparam int IW = $clog2(DEPTH);

  vram_state_e        state;
  logic [IW-1:0]      clr_idx;
  logic [VRAM_DW-1:0] mem [DEPTH];

  logic               r_in_range;
  logic               w_in_range;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      w_idx;
  logic               ready;
  logic               w_acc;
  logic [VRAM_DW-1:0] w_merged;
  logic [VRAM_DW-1:0] r_word;

  v_vram_addr_map #(
    .AW   (VRAM_AW),
    .DW   (VRAM_DW),
    .DEPTH(DEPTH),
    .IW   (IW),
    .BASE (BASE_ADDR)
  ) u_r_map (
    .addr    (vram_r_addr),
    .in_range(r_in_range),
    .idx     (r_idx)
  );

  v_vram_addr_map #(
    .AW   (VRAM_AW),
    .DW   (VRAM_DW),
    .DEPTH(DEPTH),
    .IW   (IW),
    .BASE (BASE_ADDR)
  ) u_w_map (
    .addr    (vram_w_addr),
    .in_range(w_in_range),
    .idx     (w_idx)
  );

  // A read colliding with an accepted write sees the merged word (write-first).
  always_comb begin
    ready    = (state == VRAM_ST_READY);
    w_acc    = ready && vram_w_ena && w_in_range;
    w_merged = (mem[w_idx] & ~vram_w_mask) | (vram_w_data & vram_w_mask);
    r_word   = (w_acc && (w_idx == r_idx)) ? w_merged : mem[r_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= VRAM_ST_CLEAR;
      clr_idx      <= '0;
      vram_busy    <= 1'b1;
      vram_r_data  <= '0;
      vram_r_valid <= 1'b0;
      vram_err     <= 1'b0;
    end else begin
      case (state)
        VRAM_ST_CLEAR: begin
          vram_r_valid <= 1'b0;
          vram_err     <= 1'b0;
          clr_idx      <= clr_idx + IW'(1);
          if (clr_idx == IW'(DEPTH - 1)) begin
            state     <= VRAM_ST_READY;
            vram_busy <= 1'b0;
          end
        end
        default: begin
          vram_r_valid <= vram_r_ena;
          if (vram_r_ena) begin
            vram_r_data <= r_in_range ? r_word : '0;
          end
          // One pulse covers both ports being out of range together.
          vram_err <= (vram_r_ena && !r_in_range) || (vram_w_ena && !w_in_range);
        end
      endcase
    end
  end

  // Array storage carries no reset; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (state == VRAM_ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (w_acc) begin
      mem[w_idx] <= w_merged;
    end
  end

endmodule

// File: tb/tb_v_vram_resp.sv
// Randomized and directed bench for v_vram_resp against a behavioural VRAM
// model; every cycle's outputs are compared one step after the rising edge.
module tb_v_vram_resp;

  localparam int DW    = 256;
  localparam int AW    = 64;
  localparam int DEPTH = 1024;
  localparam logic [AW-1:0] BASE = 64'h0;

  // Handshake: a request is one cycle of *_ena high, driven at the falling
  // edge; a read result is vram_r_valid with vram_r_data one cycle later.
  logic          clk;
  logic          rst;
  logic          r_ena;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          w_ena;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [DW-1:0] w_mask;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_busy;
  int            m_cnt;
  bit            m_valid;
  bit            m_err;
  logic [DW-1:0] m_data;
  bit            r_ok;
  bit            w_ok;

  v_vram_resp dut (
    .clk         (clk),
    .rst         (rst),
    .vram_r_ena  (r_ena),
    .vram_r_addr (r_addr),
    .vram_r_data (r_data),
    .vram_r_valid(r_valid),
    .vram_w_ena  (w_ena),
    .vram_w_addr (w_addr),
    .vram_w_data (w_data),
    .vram_w_mask (w_mask),
    .vram_busy   (busy),
    .vram_err    (err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [AW-1:0] a);
    return (a >= BASE) && (((a - BASE) / 32) < DEPTH);
  endfunction

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((a - BASE) / 32);
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int mode;
    mode = $urandom_range(0, 15);
    if (mode == 0) return 64'h8000 + AW'($urandom_range(0, 4095));
    if (mode == 1) return {$urandom, $urandom} | 64'h1_0000_0000;
    if (mode == 2) return 64'h7FE0 + AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 15) * 32 + $urandom_range(0, 31));
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input bit re, input logic [AW-1:0] ra, input bit we,
                     input logic [AW-1:0] wa, input logic [DW-1:0] d, input logic [DW-1:0] m);
    r_ena  = re;
    r_addr = ra;
    w_ena  = we;
    w_addr = wa;
    w_data = d;
    w_mask = m;
    @(negedge clk);
    r_ena = 1'b0;
    w_ena = 1'b0;
  endtask

  task automatic measure_clear(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 2000);
  endtask

  // ---------------- model + compare process ----------------
  initial begin
    m_busy  = 1'b1;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_data  = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy  = 1'b1;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_data  = '0;
        exp_q.delete();
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_busy = 1'b0;
          foreach (ref_mem[i]) ref_mem[i] = '0;
        end
        m_valid = 1'b0;
        m_err   = 1'b0;
      end else begin
        r_ok = in_rng(r_addr);
        w_ok = in_rng(w_addr);
        if (w_ena && w_ok)
          ref_mem[idx_of(w_addr)] = (ref_mem[idx_of(w_addr)] & ~w_mask) | (w_data & w_mask);
        m_valid = r_ena;
        if (r_ena) begin
          m_data = r_ok ? ref_mem[idx_of(r_addr)] : '0;
          exp_q.push_back(m_data);
        end
        m_err = (r_ena && !r_ok) || (w_ena && !w_ok);
      end
      #1;
      check("mon_busy", DW'(busy), DW'(m_busy));
      check("mon_valid", DW'(r_valid), DW'(m_valid));
      check("mon_err", DW'(err), DW'(m_err));
      if (m_valid) check("mon_rdata", r_data, exp_q.pop_front());
      else         check("mon_rdata_hold", r_data, m_data);
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [DW-1:0] a5;
    logic [DW-1:0] a5_ff;
    int n;
    a5    = {32{8'hA5}};
    a5_ff = {{31{8'hA5}}, 8'hFF};
    rst = 1'b1;
    r_ena = 1'b0; r_addr = '0; w_ena = 1'b0; w_addr = '0; w_data = '0; w_mask = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", DW'(busy), DW'(1));
    check("rst_valid", DW'(r_valid), DW'(0));
    check("rst_data", r_data, '0);
    check("rst_err", DW'(err), DW'(0));
    rst = 1'b0;

    measure_clear(n);
    check("clear_len", DW'(n), DW'(1024));

    cyc(1, 64'h7FE0, 0, 0, '0, '0);
    check("rd_top_data", r_data, '0);
    check("rd_top_valid", DW'(r_valid), DW'(1));

    cyc(0, 0, 1, 64'h40, a5, '1);
    cyc(1, 64'h40, 0, 0, '0, '0);
    check("rd_a5", r_data, a5);
    check("rd_a5_valid", DW'(r_valid), DW'(1));
    check("rd_a5_err", DW'(err), DW'(0));

    cyc(0, 0, 1, 64'h40, '1, DW'(8'hFF));
    cyc(1, 64'h40, 0, 0, '0, '0);
    check("rd_masked", r_data, a5_ff);
    cyc(1, 64'h5F, 0, 0, '0, '0);
    check("rd_misaligned", r_data, a5_ff);

    cyc(1, 64'h80, 1, 64'h80, DW'(16'h1234), '1);
    check("rd_write_first", r_data, DW'(16'h1234));

    cyc(0, 0, 1, 64'h8000, '1, '1);
    check("oor_wr_err", DW'(err), DW'(1));
    cyc(0, 0, 0, 0, '0, '0);
    check("oor_wr_err_end", DW'(err), DW'(0));
    cyc(1, 64'h8000, 0, 0, '0, '0);
    check("oor_rd_data", r_data, '0);
    check("oor_rd_valid", DW'(r_valid), DW'(1));
    check("oor_rd_err", DW'(err), DW'(1));
    cyc(1, 64'h9000, 1, 64'hFFFF_0000_0000_0000, '1, '1);
    check("oor_both_err", DW'(err), DW'(1));
    cyc(0, 0, 0, 0, '0, '0);
    check("oor_both_single", DW'(err), DW'(0));

    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 1), rand_addr(), $urandom_range(0, 1), rand_addr(), rand_word(),
          ($urandom_range(0, 3) == 0) ? '1 : (($urandom_range(0, 7) == 0) ? '0 : rand_word()));
    end

    // Reset while a read result is on the bus: it must vanish immediately.
    cyc(0, 0, 1, 64'h40, a5, '1);
    r_ena = 1'b1; r_addr = 64'h40;
    @(posedge clk);
    #2 rst = 1'b1;
    r_ena = 1'b0;
    #1;
    check("rst_rd_valid", DW'(r_valid), DW'(0));
    check("rst_rd_busy", DW'(busy), DW'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    measure_clear(n);
    check("clear_len_2", DW'(n), DW'(1024));
    cyc(0, 0, 1, 64'h40, a5, '1);

    // Reset in the middle of the clear restarts it from entry 0.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midclr_busy", DW'(busy), DW'(1));
    check("midclr_valid", DW'(r_valid), DW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    measure_clear(n);
    check("clear_len_3", DW'(n), DW'(1024));
    cyc(1, 64'h40, 0, 0, '0, '0);
    check("rd_after_clear", r_data, '0);
    check("rd_after_clear_valid", DW'(r_valid), DW'(1));

    repeat (2) @(negedge clk);
    check("exp_q_empty", DW'(exp_q.size()), DW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
